lcd_cmd_seq: RTL and testbench

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

---
 rtl/lcd_cmd_seq_if.sv | 35 +++
 rtl/lcd_cmd_seq.sv | 145 ++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_seq_if.sv
// Host/LCD-controller signal bundle for lcd_cmd_seq.
// tmo_err is present only when LCD_CMD_SEQ_TMO_EN is defined.
interface lcd_cmd_seq_if;
    logic [2:0] host_cmd;
    logic       host_wr;
    logic       host_full;
    logic       overflow;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       seq_done;
    logic [7:0] issued_cnt;
`ifdef LCD_CMD_SEQ_TMO_EN
    logic       tmo_err;
`endif

    // Sequencer side
    modport slave (
        input  host_cmd, host_wr, busy, done,
        output host_full, overflow, cmd, cmd_valid, seq_done, issued_cnt
`ifdef LCD_CMD_SEQ_TMO_EN
        , output tmo_err
`endif
    );

    // Host plus LCD-controller side
    modport master (
        output host_cmd, host_wr, busy, done,
        input  host_full, overflow, cmd, cmd_valid, seq_done, issued_cnt
`ifdef LCD_CMD_SEQ_TMO_EN
        , input tmo_err
`endif
    );
endinterface

// File: rtl/lcd_cmd_seq.sv
// Command FIFO plus issue sequencer feeding an LCD controller; a write-out (opcode 0) ends the run.
// Optional busy-acknowledge timeout is compiled in with LCD_CMD_SEQ_TMO_EN.
module lcd_cmd_seq #(
    parameter int DEPTH   = 8,
    parameter int TMO_CYC = 16
) (
    input  logic         clk,
    input  logic         reset,
    lcd_cmd_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("lcd_cmd_seq: DEPTH must be a power of two from 2 to 16");
        end
        if (TMO_CYC < 1) begin : g_bad_tmo
            $error("lcd_cmd_seq: TMO_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_RDY  = 3'd3,
        WAIT_DONE = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t        r_state;
    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_cmd;
    logic          r_cmd_valid;
    logic          r_overflow;
    logic          r_seq_done;
    logic [7:0]    r_issued;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_ovf;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = bus.host_wr && !w_full && (r_state != HALT);
    assign w_ovf  = bus.host_wr &&  w_full && (r_state != HALT);
    assign w_pop  = (r_state == IDLE) && !bus.busy && (r_count != '0);

    // Storage is left unreset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.host_cmd;
        end
    end

`ifdef LCD_CMD_SEQ_TMO_EN
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_err;
    assign bus.tmo_err = r_tmo_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_seq_done  <= 1'b0;
            r_issued    <= '0;
`ifdef LCD_CMD_SEQ_TMO_EN
            r_tmo_cnt   <= '0;
            r_tmo_err   <= 1'b0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf) r_overflow <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_cmd       <= r_mem[r_rd_ptr];
                        r_cmd_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_issued != 8'hFF) r_issued <= r_issued + 8'd1;
                    r_state <= (r_cmd == 3'd0) ? WAIT_DONE : WAIT_ACK;
                end
                WAIT_ACK: begin
`ifdef LCD_CMD_SEQ_TMO_EN
                    // Controller never acknowledged: flag it and move on to the next entry.
                    if (bus.busy) begin
                        r_tmo_cnt <= '0;
                        r_state   <= WAIT_RDY;
                    end else if (r_tmo_cnt == TW'(TMO_CYC - 1)) begin
                        r_tmo_cnt <= '0;
                        r_tmo_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
`else
                    if (bus.busy) r_state <= WAIT_RDY;
`endif
                end
                WAIT_RDY: begin
                    if (!bus.busy) r_state <= IDLE;
                end
                WAIT_DONE: begin
                    if (bus.done) begin
                        r_seq_done <= 1'b1;
                        r_state    <= HALT;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.host_full  = w_full;
    assign bus.overflow   = r_overflow;
    assign bus.cmd        = r_cmd;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.seq_done   = r_seq_done;
    assign bus.issued_cnt = r_issued;
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed self-checking bench for lcd_cmd_seq (DEPTH=8, TMO_CYC=16).
module tb_lcd_cmd_seq;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    int   iss_cmd[$];
    int   iss_cyc[$];
    int   done_cyc;
    int   sd_cyc;

    lcd_cmd_seq_if bus ();

    lcd_cmd_seq #(.DEPTH(8), .TMO_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        bus.host_wr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [2:0] c);
        @(negedge clk);
        bus.host_cmd = c;
        bus.host_wr  = 1'b1;
        @(posedge clk);
        #1 bus.host_wr = 1'b0;
        $display("push cmd=%0d full=%0b ovf=%0b", c, bus.host_full, bus.overflow);
    endtask

    // Controller model: busy for 3 cycles after an image op, done 3 cycles after write-out.
    task automatic run_ctrl(input int ncyc);
        int bcnt;
        int dcnt;
        bcnt = 0;
        dcnt = 0;
        iss_cmd.delete();
        iss_cyc.delete();
        done_cyc = -1;
        sd_cyc   = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus.done = 1'b0;
            if (bus.seq_done && sd_cyc < 0) sd_cyc = c;
            if (bus.cmd_valid) begin
                iss_cmd.push_back(int'(bus.cmd));
                iss_cyc.push_back(c);
                $display("issue cyc=%0d cmd=%0d cnt=%0d", c, bus.cmd, bus.issued_cnt);
                if (bus.cmd != 3'd0) begin
                    bus.busy = 1'b1;
                    bcnt = 3;
                end else begin
                    dcnt = 3;
                end
            end else begin
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) bus.busy = 1'b0;
                end
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) begin
                        bus.done = 1'b1;
                        done_cyc = c;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.busy = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid: got %0b want 0", bus.cmd_valid); end
        n_vec++; if (bus.cmd !== 3'd0) begin n_bad++; $display("FAIL rst_cmd: got %0d want 0", bus.cmd); end
        n_vec++; if (bus.issued_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_issued: got %0d want 0", bus.issued_cnt); end
        n_vec++; if ({bus.overflow, bus.seq_done, bus.host_full} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {bus.overflow, bus.seq_done, bus.host_full}); end
        reset = 1'b0;
    endtask

    task automatic test_basic_seq();
        int saw;
        int exp_cmd[3] = '{3, 5, 0};
        int exp_cyc[3] = '{0, 5, 10};
        do_reset();
        push(3'd3);
        push(3'd5);
        push(3'd0);
        saw = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.cmd_valid) saw++;
        end
        n_vec++; if (saw !== 0) begin n_bad++; $display("FAIL basic_hold_while_busy: got %0d strobes want 0", saw); end
        bus.busy = 1'b0;
        run_ctrl(20);
        n_vec++; if (iss_cmd.size() !== 3) begin n_bad++; $display("FAIL basic_issue_count: got %0d want 3", iss_cmd.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= iss_cmd.size() || iss_cmd[i] !== exp_cmd[i] || iss_cyc[i] !== exp_cyc[i]) begin
                n_bad++;
                $display("FAIL basic_issue%0d: got cmd=%0d cyc=%0d want cmd=%0d cyc=%0d", i,
                         (i < iss_cmd.size()) ? iss_cmd[i] : -1, (i < iss_cyc.size()) ? iss_cyc[i] : -1, exp_cmd[i], exp_cyc[i]);
            end
        end
        n_vec++; if (bus.issued_cnt !== 8'd3) begin n_bad++; $display("FAIL basic_issued_cnt: got %0d want 3", bus.issued_cnt); end
        n_vec++; if (done_cyc !== 13 || sd_cyc !== 14) begin n_bad++; $display("FAIL basic_seq_done: got done=%0d sd=%0d want done=13 sd=14", done_cyc, sd_cyc); end
    endtask

    task automatic test_overflow();
        logic [2:0] vals[9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd6};
        do_reset();
        for (int i = 0; i < 8; i++) push(vals[i]);
        n_vec++; if ({bus.host_full, bus.overflow} !== 2'b10) begin n_bad++; $display("FAIL ovf_full_after8: got %b want 10", {bus.host_full, bus.overflow}); end
        push(vals[8]);
        n_vec++; if ({bus.host_full, bus.overflow} !== 2'b11) begin n_bad++; $display("FAIL ovf_after9: got %b want 11", {bus.host_full, bus.overflow}); end
        n_vec++; if (dut.r_count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", dut.r_count); end
        @(negedge clk);
        bus.busy = 1'b0;
        run_ctrl(60);
        n_vec++; if (iss_cmd.size() !== 8) begin n_bad++; $display("FAIL ovf_issued: got %0d want 8", iss_cmd.size()); end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (i >= iss_cmd.size() || iss_cmd[i] !== int'(vals[i])) begin
                n_bad++;
                $display("FAIL ovf_order%0d: got %0d want %0d", i, (i < iss_cmd.size()) ? iss_cmd[i] : -1, vals[i]);
            end
        end
        n_vec++; if (bus.issued_cnt !== 8'd8) begin n_bad++; $display("FAIL ovf_issued_cnt: got %0d want 8", bus.issued_cnt); end
        n_vec++; if (bus.host_full !== 1'b0) begin n_bad++; $display("FAIL ovf_drained_full: got %0b want 0", bus.host_full); end
    endtask

    task automatic test_full_pop();
        logic [2:0] vals[8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        do_reset();
        for (int i = 0; i < 8; i++) push(vals[i]);
        @(negedge clk);
        bus.busy     = 1'b0;
        bus.host_cmd = 3'd7;
        bus.host_wr  = 1'b1;
        @(posedge clk);
        #1;
        bus.host_wr = 1'b0;
        bus.busy    = 1'b1;
        @(negedge clk);
        $display("full_pop ovf=%0b count=%0d cmd=%0d", bus.overflow, dut.r_count, bus.cmd);
        n_vec++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL fullpop_overflow: got %0b want 1", bus.overflow); end
        n_vec++; if (dut.r_count !== 4'd7) begin n_bad++; $display("FAIL fullpop_count: got %0d want 7", dut.r_count); end
        n_vec++; if ({bus.cmd_valid, bus.cmd} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL fullpop_issue: got v=%0b cmd=%0d want v=1 cmd=2", bus.cmd_valid, bus.cmd); end
        n_vec++; if (bus.host_full !== 1'b0) begin n_bad++; $display("FAIL fullpop_full: got %0b want 0", bus.host_full); end
    endtask

    task automatic test_halt();
        do_reset();
        push(3'd1);
        push(3'd0);
        push(3'd2);
        @(negedge clk);
        bus.busy = 1'b0;
        run_ctrl(40);
        n_vec++; if (iss_cmd.size() !== 2) begin n_bad++; $display("FAIL halt_issued: got %0d want 2", iss_cmd.size()); end
        n_vec++; if (iss_cmd.size() >= 2 && (iss_cmd[0] !== 1 || iss_cmd[1] !== 0)) begin n_bad++; $display("FAIL halt_order: got %0d,%0d want 1,0", iss_cmd[0], iss_cmd[1]); end
        n_vec++; if (done_cyc !== 8 || sd_cyc !== 9) begin n_bad++; $display("FAIL halt_seq_done: got done=%0d sd=%0d want done=8 sd=9", done_cyc, sd_cyc); end
        n_vec++; if (bus.issued_cnt !== 8'd2) begin n_bad++; $display("FAIL halt_issued_cnt: got %0d want 2", bus.issued_cnt); end
        for (int i = 0; i < 10; i++) push(3'd3);
        bus.busy = 1'b0;
        run_ctrl(10);
        n_vec++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL halt_overflow: got %0b want 0", bus.overflow); end
        n_vec++; if (dut.r_count !== 4'd1) begin n_bad++; $display("FAIL halt_count: got %0d want 1", dut.r_count); end
        n_vec++; if (iss_cmd.size() !== 0 || bus.seq_done !== 1'b1) begin n_bad++; $display("FAIL halt_terminal: got issues=%0d sd=%0b want 0 1", iss_cmd.size(), bus.seq_done); end
    endtask

    task automatic test_mid_reset();
        int saw;
        do_reset();
        push(3'd1);
        push(3'd2);
        push(3'd3);
        @(negedge clk);
        bus.busy = 1'b0;
        run_ctrl(3);
        #2 reset = 1'b1;
        #1;
        $display("mid_reset cmd=%0d valid=%0b cnt=%0d count=%0d", bus.cmd, bus.cmd_valid, bus.issued_cnt, dut.r_count);
        n_vec++; if ({bus.cmd_valid, bus.cmd} !== 4'b0000) begin n_bad++; $display("FAIL midrst_cmd: got v=%0b cmd=%0d want 0 0", bus.cmd_valid, bus.cmd); end
        n_vec++; if (bus.issued_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_issued: got %0d want 0", bus.issued_cnt); end
        n_vec++; if (dut.r_count !== 4'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", dut.r_count); end
        @(negedge clk);
        reset = 1'b0;
        bus.busy = 1'b0;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cmd_valid) saw++;
        end
        n_vec++; if (saw !== 0) begin n_bad++; $display("FAIL midrst_no_issue: got %0d strobes want 0", saw); end
        push(3'd6);
        run_ctrl(3);
        n_vec++; if (iss_cmd.size() !== 1 || iss_cmd[0] !== 6 || iss_cyc[0] !== 1) begin n_bad++; $display("FAIL midrst_new_issue: got n=%0d want one cmd=6 at cyc 1", iss_cmd.size()); end
    endtask

`ifdef LCD_CMD_SEQ_TMO_EN
    task automatic test_timeout();
        do_reset();
        push(3'd4);
        push(3'd5);
        @(negedge clk);
        bus.busy = 1'b0;
        for (int n = 0; n <= 18; n++) begin
            @(negedge clk);
            if (n == 0) begin
                n_vec++; if ({bus.cmd_valid, bus.cmd} !== {1'b1, 3'd4}) begin n_bad++; $display("FAIL tmo_first: got v=%0b cmd=%0d want 1 4", bus.cmd_valid, bus.cmd); end
            end
            if (n == 16) begin
                n_vec++; if (bus.tmo_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %0b want 0", bus.tmo_err); end
            end
            if (n == 17) begin
                n_vec++; if (bus.tmo_err !== 1'b1) begin n_bad++; $display("FAIL tmo_set: got %0b want 1", bus.tmo_err); end
            end
            if (n == 18) begin
                $display("tmo reissue cmd=%0d valid=%0b", bus.cmd, bus.cmd_valid);
                n_vec++; if ({bus.cmd_valid, bus.cmd} !== {1'b1, 3'd5} || bus.issued_cnt !== 8'd1) begin n_bad++; $display("FAIL tmo_next: got v=%0b cmd=%0d cnt=%0d want 1 5 1", bus.cmd_valid, bus.cmd, bus.issued_cnt); end
            end
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.host_wr  = 1'b0;
        bus.host_cmd = 3'd0;
        test_reset();
        test_basic_seq();
        test_overflow();
        test_full_pop();
        test_halt();
        test_mid_reset();
`ifdef LCD_CMD_SEQ_TMO_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
